mstreset_seq: RTL and testbench

Parametrised master reset sequencer, the successor to the single-output master reset generator. It accepts the board reset and a synchronous software reset request, and synchronises reset deassertion to `clk`. It holds all downstream resets for a programmable time, then releases `NUM_OUT` active-high reset channels one at a time, in order. It sits at the top of the MIDI-Router design and feeds every other module's reset input, including the UART, router core and host interface.

---
 rtl/mstreset_seq.sv | 137 +++++++++++++
 tb/tb_mstreset_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mstreset_seq.sv
// Master reset sequencer: synchronises board-reset release, holds all channels, then
// releases NUM_OUT active-high reset channels in index order with a fixed stagger.
module mstreset_seq #(
    parameter int unsigned NUM_OUT        = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready,
    output logic [1:0]         cause
);

    localparam int unsigned MaxCnt = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES
                                                                     : STAGGER_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CntW-1:0]    HoldCnt    = CntW'(HOLD_CYCLES);
    localparam logic [CntW-1:0]    StagCnt    = CntW'(STAGGER_CYCLES);
    localparam logic [IdxW-1:0]    IdxLast    = IdxW'(NUM_OUT - 1);
    localparam logic [IdxW-1:0]    IdxFirst   = IdxW'(1);
    localparam logic [NUM_OUT-1:0] ChanOne    = NUM_OUT'(1);
    localparam logic [1:0]         CauseBoard = 2'b01;
    localparam logic [1:0]         CauseSw    = 2'b10;

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        cnt_inc;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [NUM_OUT-1:0]     rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic [1:0]             cause_q, cause_d;
    logic                   rst_sync;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
    assign rst_sync = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt_q + CntW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            state_q   <= StAssert;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= CauseBoard;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        cause_d   = cause_q;

        // A software request wins over everything and restarts the hold from this edge.
        if (sw_req) begin
            state_d   = StAssert;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            cause_d   = CauseSw;
        end else if (rst_sync) begin
            unique case (state_q)
                StAssert: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == HoldCnt) begin
                        cnt_d = '0;
                        if (NUM_OUT == 1) begin
                            state_d   = StRun;
                            rst_out_d = '0;
                            ready_d   = 1'b1;
                        end else begin
                            state_d   = StRelease;
                            idx_d     = IdxFirst;
                            rst_out_d = rst_out_q & ~ChanOne;
                        end
                    end
                end
                StRelease: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == StagCnt) begin
                        cnt_d     = '0;
                        rst_out_d = rst_out_q & ~(ChanOne << idx_q);
                        if (idx_q == IdxLast) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                StRun: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d   = StAssert;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from flops so downstream resets never glitch.
    always_comb begin
        rst_out = rst_out_q;
        ready   = ready_q;
        cause   = cause_q;
    end

endmodule

// File: tb/tb_mstreset_seq.sv
// Bench for mstreset_seq: three parameterisations share stimulus and are checked each
// clock against release deadlines computed from the last hold origin.
module tb_mstreset_seq;

    localparam int Sync = 2;
    localparam int NA = 3, HA = 16, SA = 4;
    localparam int NB = 1, HB = 1,  SB = 4;
    localparam int NC = 8, HC = 3,  SC = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_req;
    logic [2:0] rst_a;
    logic [0:0] rst_b;
    logic [7:0] rst_c;
    logic       ready_a, ready_b, ready_c;
    logic [1:0] cause_a, cause_b, cause_c;

    int         n_cmp = 0;
    int         n_err = 0;

    // Reference model state: edge count since reset release and start of current hold.
    int         edge_n;
    int         origin;
    bit         in_rst;
    logic [1:0] cause_exp;

    always #5 clk = ~clk;

    mstreset_seq #(.NUM_OUT(NA), .SYNC_STAGES(Sync), .HOLD_CYCLES(HA), .STAGGER_CYCLES(SA))
        u_a (.clk(clk), .reset(reset), .sw_req(sw_req), .rst_out(rst_a), .ready(ready_a),
             .cause(cause_a));
    mstreset_seq #(.NUM_OUT(NB), .SYNC_STAGES(Sync), .HOLD_CYCLES(HB), .STAGGER_CYCLES(SB))
        u_b (.clk(clk), .reset(reset), .sw_req(sw_req), .rst_out(rst_b), .ready(ready_b),
             .cause(cause_b));
    mstreset_seq #(.NUM_OUT(NC), .SYNC_STAGES(Sync), .HOLD_CYCLES(HC), .STAGGER_CYCLES(SC))
        u_c (.clk(clk), .reset(reset), .sw_req(sw_req), .rst_out(rst_c), .ready(ready_c),
             .cause(cause_c));

    function automatic logic [7:0] exp_rst(int n, int h, int s);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = in_rst || (edge_n < origin + h + k * s);
        return v;
    endfunction

    function automatic logic exp_ready(int n, int h, int s);
        return !in_rst && (edge_n >= origin + h + (n - 1) * s);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_n, got, exp);
        end
    endtask

    task automatic check_all();
        check("a_rst_out", {5'b0, rst_a}, exp_rst(NA, HA, SA));
        check("a_ready", {7'b0, ready_a}, {7'b0, exp_ready(NA, HA, SA)});
        check("a_cause", {6'b0, cause_a}, {6'b0, cause_exp});
        check("b_rst_out", {7'b0, rst_b}, exp_rst(NB, HB, SB));
        check("b_ready", {7'b0, ready_b}, {7'b0, exp_ready(NB, HB, SB)});
        check("b_cause", {6'b0, cause_b}, {6'b0, cause_exp});
        check("c_rst_out", rst_c, exp_rst(NC, HC, SC));
        check("c_ready", {7'b0, ready_c}, {7'b0, exp_ready(NC, HC, SC)});
        check("c_cause", {6'b0, cause_c}, {6'b0, cause_exp});
    endtask

    // One rising edge: update the model with what the DUT sampled, then check mid-cycle.
    task automatic step();
        @(posedge clk);
        if (!in_rst) begin
            edge_n++;
            if (sw_req) begin
                origin    = edge_n;
                cause_exp = 2'b10;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic release_reset();
        reset  = 1'b1;
        in_rst = 1'b0;
        edge_n = 0;
        origin = Sync;
    endtask

    task automatic drop_reset_async();
        #2;
        reset = 1'b0;
        #1;
        in_rst    = 1'b1;
        cause_exp = 2'b01;
        check_all();
    endtask

    task automatic random_run(input int cycles, input int odds);
        for (int i = 0; i < cycles; i++) begin
            sw_req = (edge_n >= Sync) && ($urandom_range(0, odds - 1) == 0);
            step();
        end
        sw_req = 1'b0;
    endtask

    initial begin
        int len;
        reset     = 1'b1;
        sw_req    = 1'b0;
        in_rst    = 1'b1;
        edge_n    = 0;
        origin    = Sync;
        cause_exp = 2'b01;
        #2;
        reset = 1'b0;
        #1;
        check_all();

        // Power-on: five clocks in reset, then release away from the clock edge.
        repeat (5) step();
        release_reset();
        repeat (39) step();

        // Single-cycle request sampled at edge 40.
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (40) step();

        // Held request of random length.
        len = $urandom_range(2, 12);
        sw_req = 1'b1;
        repeat (len) step();
        sw_req = 1'b0;
        repeat (45) step();

        // Request landing in the middle of the release stagger.
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (HA + 2) step();
        sw_req = 1'b1;
        step();
        sw_req = 1'b0;
        repeat (40) step();

        random_run(300, 25);

        // Board reset dropped mid-sequence, between edges, several times.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 30)) step();
            if (r[0]) begin
                sw_req = 1'b1;
                repeat ($urandom_range(1, 4)) step();
                sw_req = 1'b0;
            end
            drop_reset_async();
            repeat ($urandom_range(1, 4)) step();
            release_reset();
            random_run(60, 40);
        end

        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
